// File: rtl/output_port_allocator_pkg.sv
// Shared NoC router definitions: direction codes and allocator state encoding.
// Imported by the output port allocator and its testbench.
package noc_pkg;

   localparam int NORTH = 0;
   localparam int SOUTH = 1;
   localparam int WEST  = 2;
   localparam int EAST  = 3;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } allocState_e;

endpackage

// File: rtl/output_port_allocator_rr_arbiter.sv
// Rotating-priority picker: first request at or after ptr, searching
// upward modulo N. Purely combinational.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic             anyValid
);

   logic [PTR_W-1:0] idx;

   // Scan from farthest to nearest so the nearest hit overwrites the rest.
   always_comb begin
      grant    = '0;
      anyValid = |req;
      idx      = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = PTR_W'((int'(ptr) + k) % N);
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/output_port_allocator.sv
// Output port allocator: round-robin lock of one router output to one input.
// Optional idle-lock watchdog enabled by OUTPUT_PORT_ALLOCATOR_WATCHDOG_EN.
module output_port_allocator
   import noc_pkg::*;
#(
   parameter int N             = 4,
   parameter int INDEX         = NORTH,
   parameter int REQUEST_WIDTH = 2,
   parameter int TIMEOUT       = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N-1:0]               routeReserveRequestValid,
   input  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest,
   input  logic [N-1:0]               routeRelieve,
   input  logic                       flitFire,
   output logic [N-1:0]               routeReserveStatus,
   output logic [N-1:0]               outSelect,
   output logic                       busy,
   output logic                       timeoutPulse
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [REQUEST_WIDTH-1:0] MY_DIR = REQUEST_WIDTH'(INDEX);

   allocState_e      state;
   logic [PTR_W-1:0] rrPtr;
   logic [PTR_W-1:0] owner;
   logic [PTR_W-1:0] winnerIdx;
   logic [PTR_W-1:0] nextPtr;
   logic [N-1:0]     candidate;
   logic [N-1:0]     winner;
   logic             anyCand;
   logic             expire;

   // Only requests aimed at this output's direction compete.
   always_comb begin
      candidate = '0;
      for (int i = 0; i < N; i++) begin
         candidate[i] = routeReserveRequestValid[i] &&
            (routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH] == MY_DIR);
      end
   end

   rr_arbiter #(
      .N     (N),
      .PTR_W (PTR_W)
   ) uArb (
      .req      (candidate),
      .ptr      (rrPtr),
      .grant    (winner),
      .anyValid (anyCand)
   );

   // Encode the one-hot winner and compute the post-release pointer.
   always_comb begin
      winnerIdx = '0;
      for (int i = 0; i < N; i++) begin
         if (winner[i]) winnerIdx = PTR_W'(i);
      end
      nextPtr = (owner == PTR_W'(N - 1)) ? '0 : owner + 1'b1;
   end

`ifdef OUTPUT_PORT_ALLOCATOR_WATCHDOG_EN
   logic [CNT_W-1:0] wdCnt;
   assign expire = (wdCnt == CNT_W'(TIMEOUT - 1)) && !flitFire;
`else
   logic unusedWatchdog;
   assign expire = 1'b0;
   assign unusedWatchdog = ^{flitFire, CNT_W'(TIMEOUT - 1)};
`endif

   // Allocator FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state              <= IDLE;
         rrPtr              <= '0;
         owner              <= '0;
         routeReserveStatus <= '0;
         outSelect          <= '0;
         busy               <= 1'b0;
         timeoutPulse       <= 1'b0;
`ifdef OUTPUT_PORT_ALLOCATOR_WATCHDOG_EN
         wdCnt              <= '0;
`endif
      end else begin
         timeoutPulse <= 1'b0;
         unique case (state)
            IDLE: begin
               if (anyCand) begin
                  state              <= LOCKED;
                  owner              <= winnerIdx;
                  routeReserveStatus <= winner;
                  outSelect          <= winner;
                  busy               <= 1'b1;
`ifdef OUTPUT_PORT_ALLOCATOR_WATCHDOG_EN
                  wdCnt              <= '0;
`endif
               end
            end
            LOCKED: begin
               if (routeRelieve[owner] || expire) begin
                  state              <= IDLE;
                  rrPtr              <= nextPtr;
                  routeReserveStatus <= '0;
                  outSelect          <= '0;
                  busy               <= 1'b0;
                  timeoutPulse       <= !routeRelieve[owner];
               end
`ifdef OUTPUT_PORT_ALLOCATOR_WATCHDOG_EN
               else if (flitFire) begin
                  wdCnt <= '0;
               end else begin
                  wdCnt <= wdCnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed self-checking bench for output_port_allocator (N=4, INDEX=EAST).
// Watchdog scenario runs when OUTPUT_PORT_ALLOCATOR_WATCHDOG_EN is defined.
module tb_output_port_allocator;
   import noc_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] valid;
   logic [7:0] reqBus;
   logic [3:0] relieve;
   logic       fire;
   logic [3:0] status;
   logic [3:0] sel;
   logic       busy;
   logic       pulse;

   int errors = 0;
   int checks = 0;

   output_port_allocator #(
      .N             (4),
      .INDEX         (EAST),
      .REQUEST_WIDTH (2),
      .TIMEOUT       (8)
   ) dut (
      .clk                      (clk),
      .rst                      (rst),
      .routeReserveRequestValid (valid),
      .routeReserveRequest      (reqBus),
      .routeRelieve             (relieve),
      .flitFire                 (fire),
      .routeReserveStatus       (status),
      .outSelect                (sel),
      .busy                     (busy),
      .timeoutPulse             (pulse)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] st,
                      input logic bz, input logic tp);
      checks++;
      assert (status === st && sel === st && busy === bz && pulse === tp)
      else begin
         errors++;
         $error("FAIL %s: observed st=%b sel=%b busy=%b pulse=%b expected st=%b busy=%b pulse=%b",
                tag, status, sel, busy, pulse, st, bz, tp);
      end
   endtask

   // Drive one request per input: dir field for each, valid mask.
   task automatic drive(input logic [3:0] v, input logic [1:0] d3,
                        input logic [1:0] d2, input logic [1:0] d1,
                        input logic [1:0] d0);
      valid  = v;
      reqBus = {d3, d2, d1, d0};
   endtask

   initial begin
      rst = 1'b0;
      valid = '0;
      reqBus = '0;
      relieve = '0;
      fire = 1'b0;
      step();
      step();
      chk("reset", 4'b0000, 1'b0, 1'b0);
      rst = 1'b1;

      // Single request from input 2 for EAST: grant one cycle later.
      drive(4'b0100, 2'd0, 2'd3, 2'd0, 2'd0);
      step();
      chk("grant_in2", 4'b0100, 1'b1, 1'b0);
      drive(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0);
      step();
      chk("hold_no_req", 4'b0100, 1'b1, 1'b0);
      relieve = 4'b0100;
      step();
      chk("relieve_in2", 4'b0000, 1'b0, 1'b0);
      relieve = 4'b0000;

      // Wrong direction and invalid EAST request are both ignored.
      drive(4'b0001, 2'd3, 2'd0, 2'd0, 2'd2);
      step();
      chk("wrong_dir", 4'b0000, 1'b0, 1'b0);
      drive(4'b0000, 2'd0, 2'd0, 2'd3, 2'd0);
      relieve = 4'b1111;
      step();
      chk("idle_relieve", 4'b0000, 1'b0, 1'b0);
      relieve = 4'b0000;

      // Fresh reset; inputs 0 and 2 contend, 0 wins first.
      rst = 1'b0;
      step();
      rst = 1'b1;
      drive(4'b0101, 2'd0, 2'd3, 2'd0, 2'd3);
      step();
      chk("rr_first_in0", 4'b0001, 1'b1, 1'b0);
      drive(4'b0100, 2'd0, 2'd3, 2'd0, 2'd0);
      relieve = 4'b0001;
      step();
      chk("gap_cycle", 4'b0000, 1'b0, 1'b0);
      relieve = 4'b0000;
      step();
      chk("rr_next_in2", 4'b0100, 1'b1, 1'b0);

      // Release 2 -> pointer 3; input 1 alone wins across the wrap.
      drive(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0);
      relieve = 4'b0100;
      step();
      relieve = 4'b0000;
      drive(4'b0010, 2'd0, 2'd0, 2'd3, 2'd0);
      step();
      chk("wrap_in1", 4'b0010, 1'b1, 1'b0);
      drive(4'b1001, 2'd3, 2'd0, 2'd0, 2'd3);
      relieve = 4'b1000;
      step();
      chk("nonowner_rel", 4'b0010, 1'b1, 1'b0);
      drive(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0);
      relieve = 4'b0010;
      step();
      chk("owner_rel", 4'b0000, 1'b0, 1'b0);
      relieve = 4'b0000;

      // Reset while input 3 holds, then 0 and 3 contend from pointer 0.
      drive(4'b1000, 2'd3, 2'd0, 2'd0, 2'd0);
      step();
      chk("lock_in3", 4'b1000, 1'b1, 1'b0);
      rst = 1'b0;
      step();
      chk("reset_locked", 4'b0000, 1'b0, 1'b0);
      rst = 1'b1;
      drive(4'b1001, 2'd3, 2'd0, 2'd0, 2'd3);
      step();
      chk("post_rst_in0", 4'b0001, 1'b1, 1'b0);

      // Release 0 -> pointer 1: input 3 beats input 0.
      relieve = 4'b0001;
      step();
      relieve = 4'b0000;
      step();
      chk("ptr1_in3", 4'b1000, 1'b1, 1'b0);

      // Release 3 -> pointer wraps to 0: input 0 beats input 3.
      relieve = 4'b1000;
      step();
      relieve = 4'b0000;
      step();
      chk("ptr_wrap_in0", 4'b0001, 1'b1, 1'b0);
      drive(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0);
      relieve = 4'b0001;
      step();
      relieve = 4'b0000;
      chk("idle_again", 4'b0000, 1'b0, 1'b0);

`ifdef OUTPUT_PORT_ALLOCATOR_WATCHDOG_EN
      // Lock with no traffic: forced release 8 cycles after grant.
      drive(4'b0010, 2'd0, 2'd0, 2'd3, 2'd0);
      step();
      chk("wd_grant", 4'b0010, 1'b1, 1'b0);
      drive(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0);
      for (int k = 1; k <= 7; k++) step();
      chk("wd_hold7", 4'b0010, 1'b1, 1'b0);
      step();
      chk("wd_expire8", 4'b0000, 1'b0, 1'b1);
      step();
      chk("wd_pulse_end", 4'b0000, 1'b0, 1'b0);

      // flitFire sampled at edge 5 defers the release to edge 13.
      drive(4'b0010, 2'd0, 2'd0, 2'd3, 2'd0);
      step();
      chk("wd_grant2", 4'b0010, 1'b1, 1'b0);
      drive(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0);
      for (int k = 1; k <= 12; k++) begin
         fire = (k == 5);
         step();
         if (k == 8) chk("wd_deferred8", 4'b0010, 1'b1, 1'b0);
      end
      fire = 1'b0;
      chk("wd_hold12", 4'b0010, 1'b1, 1'b0);
      step();
      chk("wd_expire13", 4'b0000, 1'b0, 1'b1);
`else
      // Without the watchdog a lock persists indefinitely.
      drive(4'b0010, 2'd0, 2'd0, 2'd3, 2'd0);
      step();
      chk("nowd_grant", 4'b0010, 1'b1, 1'b0);
      drive(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0);
      for (int k = 1; k <= 70; k++) step();
      chk("nowd_hold70", 4'b0010, 1'b1, 1'b0);
      relieve = 4'b0010;
      step();
      relieve = 4'b0000;
      chk("nowd_release", 4'b0000, 1'b0, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/output_port_allocator.md
OUTPUT_PORT_ALLOCATOR -- requirements
Module: output_port_allocator

Interface
REQ-001 Parameter N, 4, number of requesting input ports.
REQ-002 Parameter INDEX, 0, direction code of this output (0 North, 1 South, 2 West, 3 East).
REQ-003 Parameter REQUEST_WIDTH, 2, width of one route request.
REQ-004 Parameter TIMEOUT, 64, idle-lock cycles before forced release (used only with watchdog).
REQ-005 clk  input  1  sole clock; all logic rising-edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 routeReserveRequestValid  input  N  per-input request strobe.
REQ-008 routeReserveRequest  input  N*REQUEST_WIDTH  per-input requested direction; slice i = bits [i*REQUEST_WIDTH +: REQUEST_WIDTH].
REQ-009 routeRelieve  input  N  per-input release of a held route.
REQ-010 flitFire  input  1  valid&ready handshake on this output this cycle.
REQ-011 routeReserveStatus  output  N  per-input grant, one-hot or zero.
REQ-012 outSelect  output  N  crossbar select, one-hot or zero, equal to routeReserveStatus.
REQ-013 busy  output  1  output currently owned.
REQ-014 timeoutPulse  output  1  one-cycle forced-release indication.

Function
REQ-015 Input i is a candidate when routeReserveRequestValid[i]=1 and its request slice equals INDEX; other requests are ignored.
REQ-016 Two states: IDLE and LOCKED; all outputs are registered.
REQ-017 IDLE: if any candidate, the winner is the first candidate at or after rrPtr going upward modulo N; next cycle the state is LOCKED, owner=winner, routeReserveStatus[owner]=1, busy=1.
REQ-018 IDLE with no candidate: remain IDLE, outputs zero.
REQ-019 Grant latency is exactly 1 cycle from request sample to grant visible.
REQ-020 LOCKED: grant is held regardless of requests from any input, including a deasserted request from the owner.
REQ-021 LOCKED: routeRelieve[owner]=1 causes IDLE on the next cycle, grant and busy cleared, and rrPtr=(owner+1) mod N.
REQ-022 routeRelieve from a non-owner, or in IDLE, is ignored.
REQ-023 Relieve and new candidates in the same cycle: no grant is issued that cycle; arbitration occurs in the following IDLE cycle (minimum one idle cycle between owners).
REQ-024 rrPtr wraps from N-1 to 0; rrPtr width is $clog2(N), with a minimum of 1.
REQ-025 flitFire has no effect on state other than via the watchdog.

Reset
REQ-026 While rst=0 at a clock edge: state IDLE, rrPtr=0, owner=0, watchdog=0, all outputs 0.
REQ-027 Reset mid-LOCKED drops the grant on that edge without any relieve; the first post-reset arbitration starts from input 0.

Configuration
REQ-028 Macro OUTPUT_PORT_ALLOCATOR_WATCHDOG_EN defined: a counter clears on entry to LOCKED and on flitFire, and increments on every other LOCKED cycle.
REQ-029 When the counter reaches TIMEOUT-1 with no flitFire, the next cycle is IDLE with grant cleared, rrPtr=(owner+1) mod N, and timeoutPulse=1 for exactly that cycle.
REQ-030 Macro not defined: no counter exists, timeoutPulse is tied 0, and LOCKED exits only by relieve or reset.

Structure
REQ-031 Shared package noc_pkg holds the direction constants (NORTH=0, SOUTH=1, WEST=2, EAST=3) and the allocator state encoding.
REQ-032 One combinational sub-module rr_arbiter (inputs: request vector and pointer; outputs: one-hot winner and any-valid) performs the rotate-priority pick.

Verification
REQ-033 N=4, INDEX=3; input 2 requests 3 at cycle 0 -> routeReserveStatus=4'b0100 and busy=1 at cycle 1.
REQ-034 After rst, inputs 0 and 2 request simultaneously -> input 0 granted; input 0 relieves -> IDLE for one cycle, then input 2 granted (rrPtr=1).
REQ-035 Owner 1 held; input 3 raises routeRelieve -> grant unchanged; input 1 raises routeRelieve -> all outputs 0 next cycle.
REQ-036 Input 0 requests 2 while INDEX=3 -> no grant, busy stays 0.
REQ-037 rst=0 asserted while LOCKED on input 3 -> outputs 0 on that edge; after release, requests from 0 and 3 -> input 0 wins.
REQ-038 Watchdog macro defined, TIMEOUT=8: lock with no flitFire -> release and timeoutPulse=1 on the 8th cycle after grant; one flitFire at cycle 5 defers release to cycle 13.
